addpath_fetch: RTL and testbench
================================

# addpath_fetch

Instruction fetch/decode front-end for the add datapath. It walks the instruction RAM from a start address, one word per cycle, and slices each 64-bit word into register-select and opcode fields. The decoded instruction goes downstream over a valid/ready handshake. Fetch stops on a HALT opcode or at the last RAM address. It sits directly upstream of the datapath, drives the RAM address port and consumes its combinational read data.

## Interface
Parameters:
- ADDR_W, 14, RAM address width
- DATA_W, 64, RAM word width
- START_ADDR, 0, first address fetched after `start`
- LAST_ADDR, 10484, highest valid RAM address; fetch never exceeds it
- OP_HALT, 7'h7F, opcode that terminates fetch

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  single-cycle pulse; begins a run from START_ADDR
- adr  out  ADDR_W  RAM address (drives RAM `adr`)
- readData  in  DATA_W  RAM read data, combinational from `adr`
- writeEn  out  1  RAM write enable; tied 0 by this block
- out_valid  out  1  decoded instruction available
- out_ready  in  1  downstream accepts when valid && ready
- f0, f1, f2  out  6  fields readData[5:0], [11:6], [17:12]
- op  out  7  field readData[24:18]
- out_pc  out  ADDR_W  address the presented instruction came from
- busy  out  1  high in RUN and DRAIN
- done  out  1  high in DONE
- instr_count  out  ADDR_W+1  instructions accepted downstream this run

## Operation
- States: IDLE, RUN, DRAIN, DONE. Reset → IDLE.
- IDLE/DONE: `start`=1 → pc←START_ADDR, instr_count←0, done←0, state→RUN. `start` in RUN/DRAIN is ignored.
- adr = pc at all times.
- RUN: load = !out_valid || out_ready. On load:
  - op ≠ OP_HALT: register fields, out_pc←pc, out_valid←1. If pc==LAST_ADDR → DRAIN, else pc←pc+1.
  - op == OP_HALT: word is not forwarded, out_valid←0, state→DRAIN; pc holds.
- No load: outputs and pc hold, stable while valid && !ready.
- DRAIN: no fetch. Once out_valid==0, or the handshake completes this cycle, out_valid←0 → DONE.
- instr_count increments on every out_valid && out_ready, in any state.
- readData[63:25] is ignored. pc never wraps; LAST_ADDR is a hard stop.

## Timing
- Reset values: adr=0, out_valid=0, f0/f1/f2/op=0, out_pc=0, busy=0, done=0, instr_count=0, writeEn=0.
- Reset asserted mid-run aborts immediately; the pending output is dropped and state returns to IDLE.
- `start` at edge N → RUN in cycle N+1 with adr=START_ADDR. First out_valid in cycle N+2.
- Latency adr→output is 1 cycle. Throughput is 1 instruction/cycle with out_ready held high.
- HALT at pc=k, ready high: last instruction presented in cycle with out_pc=k-1; done=1 two cycles after HALT captured.
- Simultaneous handshake + load: the old word is counted and the new word replaces it in the same edge, with no bubble.

## Structure
- Package addpath_pkg: ADDR_W, DATA_W, field LSB/MSB constants (F0 5:0, F1 11:6, F2 17:12, OP 24:18), OP_HALT, state enum.
- One sub-module: addpath_instr_fields, a combinational slicer from a DATA_W word to f0/f1/f2/op. It is reused by the datapath.

## Test plan
- mem[0]={op=2,f2=1,f1=0,f0=0}, mem[1]={op=0,f2=2,f1=1,f0=0}, mem[2]=HALT, ready=1, start → out_pc 0 then 1 in consecutive cycles with matching fields; done=1; instr_count=2; HALT never presented.
- Same program, out_ready low for 3 cycles while word 0 is presented → fields/out_pc stable, adr stuck at 1, no loss or duplication; count=2 at end.
- LAST_ADDR=3, no HALT in mem[0..3] → exactly 4 instructions (out_pc 0..3), adr never exceeds 3, DONE.
- rst_n dropped asynchronously with out_valid=1 mid-run → all outputs zero the same instant; `start` after release reruns from 0 correctly.
- `start` pulsed during RUN → ignored, sequence unchanged. `start` in DONE → done clears, count restarts at 0.
- mem[0]=HALT → zero instructions, done=1 by cycle N+3, instr_count=0.

Source files
------------

// File: rtl/addpath_pkg.sv
// Shared constants, state encoding and decoded-instruction payload for the add datapath.
package addpath_pkg;

    localparam int unsigned ADDR_W  = 14;
    localparam int unsigned DATA_W  = 64;
    localparam int unsigned FIELD_W = 6;
    localparam int unsigned OP_W    = 7;

    localparam int unsigned F0_LSB = 0;
    localparam int unsigned F0_MSB = 5;
    localparam int unsigned F1_LSB = 6;
    localparam int unsigned F1_MSB = 11;
    localparam int unsigned F2_LSB = 12;
    localparam int unsigned F2_MSB = 17;
    localparam int unsigned OP_LSB = 18;
    localparam int unsigned OP_MSB = 24;

    localparam logic [OP_W-1:0] OP_HALT = 7'h7F;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef struct packed {
        logic [OP_W-1:0]    op;
        logic [FIELD_W-1:0] f2;
        logic [FIELD_W-1:0] f1;
        logic [FIELD_W-1:0] f0;
    } instr_t;

endpackage

// File: rtl/addpath_fetch_if.sv
// Decoded-instruction valid/ready channel from the fetch front-end to the datapath.
interface addpath_fetch_if #(
    parameter int unsigned ADDR_W = addpath_pkg::ADDR_W
) ();

    logic                               out_valid;
    logic                               out_ready;
    logic [addpath_pkg::FIELD_W-1:0]    f0;
    logic [addpath_pkg::FIELD_W-1:0]    f1;
    logic [addpath_pkg::FIELD_W-1:0]    f2;
    logic [addpath_pkg::OP_W-1:0]       op;
    logic [ADDR_W-1:0]                  out_pc;

    modport master (
        output out_valid, f0, f1, f2, op, out_pc,
        input  out_ready
    );

    modport slave (
        input  out_valid, f0, f1, f2, op, out_pc,
        output out_ready
    );

endinterface

// File: rtl/addpath_instr_fields.sv
// Combinational slicer of a RAM word into register-select and opcode fields.
module addpath_instr_fields
    import addpath_pkg::*;
(
    input  logic [DATA_W-1:0]  word,
    output logic [FIELD_W-1:0] f0_c,
    output logic [FIELD_W-1:0] f1_c,
    output logic [FIELD_W-1:0] f2_c,
    output logic [OP_W-1:0]    op_c
);

    // Upper word bits carry no meaning for this instruction format.
    logic unused_hi;
    assign unused_hi = ^word[DATA_W-1:OP_MSB+1];

    assign f0_c = word[F0_MSB:F0_LSB];
    assign f1_c = word[F1_MSB:F1_LSB];
    assign f2_c = word[F2_MSB:F2_LSB];
    assign op_c = word[OP_MSB:OP_LSB];

endmodule

// File: rtl/addpath_fetch.sv
// Instruction fetch/decode front-end: walks RAM from START_ADDR, presents decoded
// words over valid/ready, and stops on HALT or at LAST_ADDR.
module addpath_fetch #(
    parameter int unsigned ADDR_W     = addpath_pkg::ADDR_W,
    parameter int unsigned DATA_W     = addpath_pkg::DATA_W,
    parameter int unsigned START_ADDR = 0,
    parameter int unsigned LAST_ADDR  = 10484,
    parameter logic [addpath_pkg::OP_W-1:0] OP_HALT = addpath_pkg::OP_HALT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic [ADDR_W-1:0]   adr,
    input  logic [DATA_W-1:0]   readData,
    output logic                writeEn,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W:0]     instr_count,
    addpath_fetch_if.master     dn
);

    import addpath_pkg::FIELD_W;
    import addpath_pkg::OP_W;
    import addpath_pkg::instr_t;
    import addpath_pkg::state_e;
    import addpath_pkg::ST_IDLE;
    import addpath_pkg::ST_RUN;
    import addpath_pkg::ST_DRAIN;
    import addpath_pkg::ST_DONE;

    localparam int unsigned CNT_W = ADDR_W + 1;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [ADDR_W-1:0]   out_pc_q, out_pc_d;
    instr_t              instr_q, instr_d;
    logic                valid_q, valid_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                busy_q, done_q;

    logic [FIELD_W-1:0]  f0_c, f1_c, f2_c;
    logic [OP_W-1:0]     op_c;
    logic                hs_c, load_c;

    addpath_instr_fields u_fields (
        .word (readData[addpath_pkg::DATA_W-1:0]),
        .f0_c (f0_c),
        .f1_c (f1_c),
        .f2_c (f2_c),
        .op_c (op_c)
    );

    assign hs_c   = valid_q && dn.out_ready;
    assign load_c = !valid_q || dn.out_ready;

    // Next-state and next-register logic.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        out_pc_d = out_pc_q;
        instr_d  = instr_q;
        valid_d  = valid_q;
        cnt_d    = cnt_q;

        if (hs_c) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    pc_d    = ADDR_W'(START_ADDR);
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (load_c) begin
                    if (op_c != OP_HALT) begin
                        instr_d  = '{op: op_c, f2: f2_c, f1: f1_c, f0: f0_c};
                        out_pc_d = pc_q;
                        valid_d  = 1'b1;
                        if (pc_q == ADDR_W'(LAST_ADDR)) begin
                            state_d = ST_DRAIN;
                        end else begin
                            pc_d = pc_q + ADDR_W'(1);
                        end
                    end else begin
                        valid_d = 1'b0;
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (!valid_q || hs_c) begin
                    valid_d = 1'b0;
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            pc_q     <= '0;
            out_pc_q <= '0;
            instr_q  <= '0;
            valid_q  <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            out_pc_q <= out_pc_d;
            instr_q  <= instr_d;
            valid_q  <= valid_d;
            cnt_q    <= cnt_d;
            busy_q   <= (state_d == ST_RUN) || (state_d == ST_DRAIN);
            done_q   <= (state_d == ST_DONE);
        end
    end

    assign adr          = pc_q;
    assign writeEn      = 1'b0;
    assign busy         = busy_q;
    assign done         = done_q;
    assign instr_count  = cnt_q;
    assign dn.out_valid = valid_q;
    assign dn.out_pc    = out_pc_q;
    assign dn.f0        = instr_q.f0;
    assign dn.f1        = instr_q.f1;
    assign dn.f2        = instr_q.f2;
    assign dn.op        = instr_q.op;

endmodule

// File: tb/tb_addpath_fetch.sv
// Directed bench for addpath_fetch: default-parameter instance plus a LAST_ADDR=3 instance.
module tb_addpath_fetch;

    localparam int unsigned AW = 14;
    localparam int unsigned DW = 64;

    logic          clk;
    logic          rst_n;
    logic          start_a, start_b;
    logic [AW-1:0] adr_a, adr_b;
    logic [DW-1:0] rdata_a, rdata_b;
    logic          we_a, we_b;
    logic          busy_a, busy_b, done_a, done_b;
    logic [AW:0]   cnt_a, cnt_b;

    logic [DW-1:0] mem_a [16];
    logic [DW-1:0] mem_b [16];

    int n_checks;
    int n_errors;

    addpath_fetch_if #(.ADDR_W(AW)) dn_a ();
    addpath_fetch_if #(.ADDR_W(AW)) dn_b ();

    addpath_fetch u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start_a),
        .adr         (adr_a),
        .readData    (rdata_a),
        .writeEn     (we_a),
        .busy        (busy_a),
        .done        (done_a),
        .instr_count (cnt_a),
        .dn          (dn_a)
    );

    addpath_fetch #(.LAST_ADDR(3)) u_last (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start_b),
        .adr         (adr_b),
        .readData    (rdata_b),
        .writeEn     (we_b),
        .busy        (busy_b),
        .done        (done_b),
        .instr_count (cnt_b),
        .dn          (dn_b)
    );

    // Combinational RAM models; addresses beyond the table read as zero.
    always_comb rdata_a = (adr_a < AW'(16)) ? mem_a[adr_a[3:0]] : '0;
    always_comb rdata_b = (adr_b < AW'(16)) ? mem_b[adr_b[3:0]] : '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mk(input logic [6:0] op, input logic [5:0] f2,
                                         input logic [5:0] f1, input logic [5:0] f0);
        logic [38:0] junk;
        junk = 39'h2A_AAAA_AAAA;
        return {junk, op, f2, f1, f0};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Three-word program (two adds then HALT) with ready held high.
    task automatic run_basic(input string tag, input bit poke_start);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        check({tag, "_run_adr"},   64'(adr_a), 64'(0));
        check({tag, "_run_busy"},  64'(busy_a), 64'(1));
        check({tag, "_run_valid"}, 64'(dn_a.out_valid), 64'(0));
        check({tag, "_run_done"},  64'(done_a), 64'(0));
        check({tag, "_run_cnt"},   64'(cnt_a), 64'(0));
        if (poke_start) start_a = 1'b1;
        tick();
        check({tag, "_w0_valid"}, 64'(dn_a.out_valid), 64'(1));
        check({tag, "_w0_pc"},    64'(dn_a.out_pc), 64'(0));
        check({tag, "_w0_op"},    64'(dn_a.op), 64'(2));
        check({tag, "_w0_f2"},    64'(dn_a.f2), 64'(1));
        check({tag, "_w0_f1f0"},  64'({dn_a.f1, dn_a.f0}), 64'(0));
        check({tag, "_w0_adr"},   64'(adr_a), 64'(1));
        tick();
        start_a = 1'b0;
        check({tag, "_w1_valid"}, 64'(dn_a.out_valid), 64'(1));
        check({tag, "_w1_pc"},    64'(dn_a.out_pc), 64'(1));
        check({tag, "_w1_op"},    64'(dn_a.op), 64'(0));
        check({tag, "_w1_f2"},    64'(dn_a.f2), 64'(2));
        check({tag, "_w1_f1"},    64'(dn_a.f1), 64'(1));
        check({tag, "_w1_cnt"},   64'(cnt_a), 64'(1));
        tick();
        check({tag, "_halt_valid"}, 64'(dn_a.out_valid), 64'(0));
        check({tag, "_halt_cnt"},   64'(cnt_a), 64'(2));
        check({tag, "_halt_busy"},  64'(busy_a), 64'(1));
        check({tag, "_halt_done"},  64'(done_a), 64'(0));
        tick();
        check({tag, "_end_done"}, 64'(done_a), 64'(1));
        check({tag, "_end_busy"}, 64'(busy_a), 64'(0));
        check({tag, "_end_cnt"},  64'(cnt_a), 64'(2));
        check({tag, "_end_adr"},  64'(adr_a), 64'(2));
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        for (int i = 0; i < 16; i++) begin
            mem_a[i] = mk(7'd0, 6'd0, 6'd0, 6'd0);
            mem_b[i] = mk(7'd1, 6'd9, 6'd3, 6'(i));
        end
        mem_a[0] = mk(7'd2, 6'd1, 6'd0, 6'd0);
        mem_a[1] = mk(7'd0, 6'd2, 6'd1, 6'd0);
        mem_a[2] = mk(7'h7F, 6'd0, 6'd0, 6'd0);

        rst_n = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        dn_a.out_ready = 1'b1;
        dn_b.out_ready = 1'b1;
        #12;
        check("rst_adr",   64'(adr_a), 64'(0));
        check("rst_valid", 64'(dn_a.out_valid), 64'(0));
        check("rst_fields", 64'({dn_a.op, dn_a.f2, dn_a.f1, dn_a.f0}), 64'(0));
        check("rst_pc",    64'(dn_a.out_pc), 64'(0));
        check("rst_busy",  64'(busy_a), 64'(0));
        check("rst_done",  64'(done_a), 64'(0));
        check("rst_cnt",   64'(cnt_a), 64'(0));
        check("rst_we",    64'(we_a), 64'(0));
        rst_n = 1'b1;
        tick();

        run_basic("basic", 1'b0);

        // Back-pressure on word 0 for three edges, started from DONE.
        dn_a.out_ready = 1'b0;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        check("stall_done_clr", 64'(done_a), 64'(0));
        check("stall_cnt_clr",  64'(cnt_a), 64'(0));
        check("stall_adr0",     64'(adr_a), 64'(0));
        tick();
        check("stall_w0_pc", 64'(dn_a.out_pc), 64'(0));
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_hold_valid", 64'(dn_a.out_valid), 64'(1));
            check("stall_hold_pc",    64'(dn_a.out_pc), 64'(0));
            check("stall_hold_op",    64'(dn_a.op), 64'(2));
            check("stall_hold_adr",   64'(adr_a), 64'(1));
            check("stall_hold_cnt",   64'(cnt_a), 64'(0));
        end
        dn_a.out_ready = 1'b1;
        tick();
        check("stall_w1_pc",  64'(dn_a.out_pc), 64'(1));
        check("stall_w1_cnt", 64'(cnt_a), 64'(1));
        tick();
        check("stall_halt_valid", 64'(dn_a.out_valid), 64'(0));
        tick();
        check("stall_end_done", 64'(done_a), 64'(1));
        check("stall_end_cnt",  64'(cnt_a), 64'(2));

        // Asynchronous reset while word 1 is presented.
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        tick();
        tick();
        check("abort_pre_valid", 64'(dn_a.out_valid), 64'(1));
        check("abort_pre_cnt",   64'(cnt_a), 64'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_valid", 64'(dn_a.out_valid), 64'(0));
        check("abort_pc",    64'(dn_a.out_pc), 64'(0));
        check("abort_op",    64'(dn_a.op), 64'(0));
        check("abort_f2",    64'(dn_a.f2), 64'(0));
        check("abort_adr",   64'(adr_a), 64'(0));
        check("abort_busy",  64'(busy_a), 64'(0));
        check("abort_cnt",   64'(cnt_a), 64'(0));
        #2;
        rst_n = 1'b1;
        tick();
        run_basic("rerun_poke", 1'b1);

        // HALT as the very first word.
        mem_a[0] = mk(7'h7F, 6'd5, 6'd5, 6'd5);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        tick();
        check("h0_valid", 64'(dn_a.out_valid), 64'(0));
        check("h0_busy",  64'(busy_a), 64'(1));
        tick();
        check("h0_done", 64'(done_a), 64'(1));
        check("h0_cnt",  64'(cnt_a), 64'(0));
        check("h0_adr",  64'(adr_a), 64'(0));

        // LAST_ADDR=3 hard stop with no HALT in the program.
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        check("last_adr0", 64'(adr_b), 64'(0));
        for (int i = 0; i < 4; i++) begin
            tick();
            check("last_valid", 64'(dn_b.out_valid), 64'(1));
            check("last_pc",    64'(dn_b.out_pc), 64'(i));
            check("last_f0",    64'(dn_b.f0), 64'(i));
            check("last_adr",   64'(adr_b), 64'((i < 3) ? i + 1 : 3));
            check("last_cnt",   64'(cnt_b), 64'(i));
        end
        check("last_drain_busy", 64'(busy_b), 64'(1));
        tick();
        check("last_end_valid", 64'(dn_b.out_valid), 64'(0));
        check("last_end_done",  64'(done_b), 64'(1));
        check("last_end_cnt",   64'(cnt_b), 64'(4));
        check("last_end_adr",   64'(adr_b), 64'(3));
        check("last_we",        64'(we_b), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
